iddmm_ctrl: RTL and testbench
=============================

Name: iddmm_ctrl

Overview:
- Sequencer for the `iddmm_cal` Montgomery datapath. Accepts one multiply job and drives the i/j loop counters and `loop_en` into the datapath.
- Issues operand-RAM read addresses one cycle ahead of the counters.
- Waits for `cal_done`, then uses `cal_sign` to choose which result FIFO (a-path or subtracted path) is drained to the output stream. The other FIFO is flushed.

Parameters:
- K, 256, bits per word
- N, 16, words per operand
- ADDR_W, $clog2(N), word-index width
- ITER_GAP, 8, idle cycles inserted between outer iterations; covers q-update feedback latency
- DONE_TIMEOUT, 64, max cycles allowed from the last issued j to `cal_done`

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  job request
- start_ready  out  1  high only in IDLE
- rd_en  out  1  operand RAM read strobe
- rd_i_addr  out  ADDR_W  x word index
- rd_j_addr  out  ADDR_W+1  y/p/a word index
- i_cnt  out  ADDR_W  to datapath
- j_cnt  out  ADDR_W+1  to datapath
- loop_en  out  1  to datapath
- cal_done  in  1  datapath completion pulse
- cal_sign  in  1  1 = take a-FIFO, 0 = take sub-FIFO
- fifo_rd_en_a  out  1  pop a-FIFO
- fifo_rd_data_a  in  K  a-FIFO head
- fifo_rd_en_sub  out  1  pop sub-FIFO
- fifo_rd_data_sub  in  K  sub-FIFO head
- res_valid  out  1  result word valid
- res_data  out  K  result word
- res_last  out  1  marks word N-1
- res_ready  in  1  downstream accept
- busy  out  1  high outside IDLE
- err_timeout  out  1  sticky; cleared by next accepted start

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0, except `j_cnt` = PARK (N+1) and `start_ready` = 1.
- PARK value: `j_cnt` is held at PARK whenever `loop_en` = 0. Never park at 0, because `j_cnt`=0 forces the datapath q-mux. Never park at N, because N updates carry.
- Output registering: every output is registered.
- Address lead: `rd_*` lead `i_cnt`/`j_cnt`/`loop_en` by exactly 1 cycle. The counters are the `rd_*` values delayed one cycle, and `loop_en` is `rd_en` delayed one cycle.
- States: IDLE, RUN, GAP, WAIT_DONE, DRAIN.
- IDLE: on start_valid && start_ready, go to RUN with i=0, j=0.
- RUN:
  - `rd_en`=1, `rd_j_addr`=j, `rd_i_addr`=i; j increments 0..N, so N+1 cycles per iteration.
  - At j==N: if i==N-1, go to WAIT_DONE; otherwise go to GAP, gap counter=ITER_GAP.
  - `start_valid` is ignored (`start_ready`=0).
- GAP:
  - `rd_en`=0; after ITER_GAP cycles, i++ and go to RUN with j=0.
  - ITER_GAP=0 is legal: go straight to RUN.
- WAIT_DONE:
  - Timer counts from 0.
  - When `cal_done` arrives, latch `cal_sign` into `sel_a` and go to DRAIN with word cnt=0.
  - If the timer reaches DONE_TIMEOUT before `cal_done`: set `err_timeout`, go to IDLE, issue no FIFO pops.
  - `cal_done` on the same cycle as the timeout: treat as done (done wins).
- DRAIN:
  - The same pop is applied to both FIFOs each cycle, so both stay aligned.
  - `res_data` comes from the FIFO selected by `sel_a`.
  - A pop occurs when the output register is empty or when res_valid && res_ready.
  - The output register holds data while res_valid && !res_ready (no drop, no duplicate).
  - `res_last`=1 on word N-1. After it is accepted, go to IDLE.
- Totals:
  - Total issue cycles = N*(N+1) + (N-1)*ITER_GAP.
  - The first `loop_en` occurs 2 cycles after the start handshake.
- `cal_done` outside WAIT_DONE is ignored.
- Reset mid-operation: async return to IDLE and reset values; FIFO contents are the integrator's responsibility.

Decomposition:
- Package `iddmm_pkg`:
  - state enum `iddmm_ctrl_state_t`
  - localparam PARK = N+1
  - function computing the total issue-cycle count, for benches
- One sub-module: `iddmm_res_skid`, a 1-entry output register with ready/valid hold used in DRAIN.
- Loop counters stay inline.

Test Plan:
- N=4, ITER_GAP=2, single start → `loop_en` high in 4 bursts of 5 cycles separated by 2 idle cycles. `j_cnt` runs 0,1,2,3,4 then parks at 5. `i_cnt` runs 0..3. `rd_*` lead by 1 cycle. 26 issue cycles in total.
- Model `cal_done` 10 cycles after the last j with `cal_sign`=1; a-FIFO holds 0xA0..0xA3, sub-FIFO holds 0xB0..0xB3 → output 0xA0..0xA3, `res_last` on 0xA3, 4 pops on each FIFO, return to IDLE.
- Same flow with `cal_sign`=0 and `res_ready` toggling 1,0,0,1 → output 0xB0..0xB3 in order, data stable while stalled, no duplicates.
- Never assert `cal_done`, DONE_TIMEOUT=64 → `err_timeout`=1 exactly 64 cycles after the last j, IDLE, zero FIFO pops. Next start clears `err_timeout`.
- Assert `rst_n` low during GAP of i=2 → `loop_en`=0, `j_cnt`=5, `busy`=0 immediately (async). A new start after release begins at i=0.
- `start_valid` held high throughout → exactly one job accepted per IDLE visit; `cal_done` pulsed during RUN has no effect.

Source files
------------

// File: rtl/iddmm_pkg.sv
// Shared types and helpers for the iddmm_cal sequencer.
package iddmm_pkg;

    localparam int IDDMM_N = 16;
    // j_cnt rest value: 0 would force the q-mux, N would update the carry.
    localparam int PARK = IDDMM_N + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_WAIT_DONE,
        S_DRAIN
    } iddmm_ctrl_state_t;

    function automatic int park_value(input int n);
        return n + 1;
    endfunction

    function automatic int total_issue_cycles(input int n, input int iter_gap);
        return n * (n + 1) + (n - 1) * iter_gap;
    endfunction

endpackage

// File: rtl/iddmm_res_skid.sv
// One-entry result register that pops the result FIFOs only into a slot known to be free.
module iddmm_res_skid #(
    parameter int K = 256,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         active,
    input  logic [K-1:0] in_data,
    input  logic         res_ready,
    output logic         pop,
    output logic         res_valid,
    output logic [K-1:0] res_data,
    output logic         res_last
);

    localparam int CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] cap_cnt;
    logic             take;
    logic             leave;
    logic             valid_n;
    logic             issue;

    // A registered pop captures the FIFO head at the end of its own cycle.
    assign take  = pop;
    assign leave = res_valid && res_ready;

    always_comb begin
        valid_n = res_valid;
        if (take) begin
            valid_n = 1'b1;
        end else if (leave) begin
            valid_n = 1'b0;
        end
        issue = !valid_n && (pop_cnt != CNT_W'(N));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop       <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
            pop_cnt   <= '0;
            cap_cnt   <= '0;
        end else if (!active) begin
            pop       <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            pop_cnt   <= '0;
            cap_cnt   <= '0;
        end else begin
            res_valid <= valid_n;
            pop       <= issue;
            if (issue) begin
                pop_cnt <= pop_cnt + CNT_W'(1);
            end
            if (take) begin
                res_data <= in_data;
                res_last <= (cap_cnt == CNT_W'(N - 1));
                cap_cnt  <= cap_cnt + CNT_W'(1);
            end else if (leave) begin
                res_last <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/iddmm_ctrl.sv
// Job sequencer for the iddmm_cal datapath: i/j loop issue, completion wait, result drain.
module iddmm_ctrl
    import iddmm_pkg::*;
#(
    parameter int K            = 256,
    parameter int N            = 16,
    parameter int ADDR_W       = $clog2(N),
    parameter int ITER_GAP     = 8,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_i_addr,
    output logic [ADDR_W:0]   rd_j_addr,
    output logic [ADDR_W-1:0] i_cnt,
    output logic [ADDR_W:0]   j_cnt,
    output logic              loop_en,
    input  logic              cal_done,
    input  logic              cal_sign,
    output logic              fifo_rd_en_a,
    input  logic [K-1:0]      fifo_rd_data_a,
    output logic              fifo_rd_en_sub,
    input  logic [K-1:0]      fifo_rd_data_sub,
    output logic              res_valid,
    output logic [K-1:0]      res_data,
    output logic              res_last,
    input  logic              res_ready,
    output logic              busy,
    output logic              err_timeout,
    output iddmm_ctrl_state_t dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; a valid source holds its data unchanged until that edge.

    localparam int GAP_W = $clog2(ITER_GAP + 2);
    localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [ADDR_W:0]   J_PARK = (ADDR_W + 1)'(park_value(N));
    localparam logic [ADDR_W:0]   J_LAST = (ADDR_W + 1)'(N);
    localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(N - 1);

    iddmm_ctrl_state_t state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              sel_a_q, sel_a_d;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_i_d;
    logic [ADDR_W:0]   rd_j_d;
    logic              err_d;
    logic              skid_pop;
    logic [K-1:0]      skid_in;

    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        timer_d = '0;
        sel_a_d = sel_a_q;
        rd_en_d = 1'b0;
        rd_i_d  = rd_i_addr;
        rd_j_d  = '0;
        err_d   = err_timeout;
        case (state_q)
            S_IDLE: begin
                if (start_valid && start_ready) begin
                    state_d = S_RUN;
                    rd_en_d = 1'b1;
                    rd_i_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (rd_j_addr == J_LAST) begin
                    if (rd_i_addr == I_LAST) begin
                        state_d = S_WAIT_DONE;
                    end else if (ITER_GAP == 0) begin
                        rd_en_d = 1'b1;
                        rd_i_d  = rd_i_addr + ADDR_W'(1);
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_W'(ITER_GAP);
                    end
                end else begin
                    rd_en_d = 1'b1;
                    rd_j_d  = rd_j_addr + (ADDR_W + 1)'(1);
                end
            end
            S_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_RUN;
                    rd_en_d = 1'b1;
                    rd_i_d  = rd_i_addr + ADDR_W'(1);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_WAIT_DONE: begin
                // Completion takes priority over a timeout in the same cycle.
                if (cal_done) begin
                    state_d = S_DRAIN;
                    sel_a_d = cal_sign;
                end else if (timer_q == TMR_W'(DONE_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DRAIN: begin
                if (res_valid && res_ready && res_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            timer_q     <= '0;
            sel_a_q     <= 1'b0;
            rd_en       <= 1'b0;
            rd_i_addr   <= '0;
            rd_j_addr   <= '0;
            i_cnt       <= '0;
            j_cnt       <= J_PARK;
            loop_en     <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            timer_q     <= timer_d;
            sel_a_q     <= sel_a_d;
            rd_en       <= rd_en_d;
            rd_i_addr   <= rd_i_d;
            rd_j_addr   <= rd_j_d;
            // Datapath counters trail the read addresses by one cycle.
            i_cnt       <= rd_i_addr;
            j_cnt       <= rd_en ? rd_j_addr : J_PARK;
            loop_en     <= rd_en;
            start_ready <= (state_d == S_IDLE);
            busy        <= (state_d != S_IDLE);
            err_timeout <= err_d;
        end
    end

    assign skid_in = sel_a_q ? fifo_rd_data_a : fifo_rd_data_sub;

    iddmm_res_skid #(
        .K (K),
        .N (N)
    ) u_res_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (state_q == S_DRAIN),
        .in_data   (skid_in),
        .res_ready (res_ready),
        .pop       (skid_pop),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_last  (res_last)
    );

    // Both FIFOs advance together so the unselected one is flushed in step.
    assign fifo_rd_en_a   = skid_pop;
    assign fifo_rd_en_sub = skid_pop;

endmodule

// File: tb/tb_iddmm_ctrl.sv
// Directed bench for iddmm_ctrl with N=4, ITER_GAP=2, DONE_TIMEOUT=64.
module tb_iddmm_ctrl;
    import iddmm_pkg::*;

    localparam int K       = 16;
    localparam int N       = 4;
    localparam int AW      = 2;
    localparam int G       = 2;
    localparam int TO      = 64;
    localparam int PERIOD  = N + 1 + G;
    localparam int T_ISSUE = 26;     // 4*5 issue cycles + 3*2 gap cycles
    localparam int LAST_LE = T_ISSUE + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start_valid, start_ready, rd_en, loop_en;
    logic [AW-1:0]     rd_i_addr, i_cnt;
    logic [AW:0]       rd_j_addr, j_cnt;
    logic              cal_done, cal_sign;
    logic              fifo_rd_en_a, fifo_rd_en_sub;
    logic [K-1:0]      fifo_rd_data_a, fifo_rd_data_sub;
    logic              res_valid, res_last, res_ready, busy, err_timeout;
    logic [K-1:0]      res_data;
    iddmm_ctrl_state_t dbg_state;

    iddmm_ctrl #(.K(K), .N(N), .ADDR_W(AW), .ITER_GAP(G), .DONE_TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_valid      (start_valid),
        .start_ready      (start_ready),
        .rd_en            (rd_en),
        .rd_i_addr        (rd_i_addr),
        .rd_j_addr        (rd_j_addr),
        .i_cnt            (i_cnt),
        .j_cnt            (j_cnt),
        .loop_en          (loop_en),
        .cal_done         (cal_done),
        .cal_sign         (cal_sign),
        .fifo_rd_en_a     (fifo_rd_en_a),
        .fifo_rd_data_a   (fifo_rd_data_a),
        .fifo_rd_en_sub   (fifo_rd_en_sub),
        .fifo_rd_data_sub (fifo_rd_data_sub),
        .res_valid        (res_valid),
        .res_data         (res_data),
        .res_last         (res_last),
        .res_ready        (res_ready),
        .busy             (busy),
        .err_timeout      (err_timeout),
        .dbg_state        (dbg_state)
    );

    // ---------------- show-ahead FIFO models ----------------
    logic [K-1:0] a_mem [N];
    logic [K-1:0] sub_mem [N];
    int           a_ptr = 0;
    int           sub_ptr = 0;
    logic         fifo_clr = 1'b0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            a_ptr   <= 0;
            sub_ptr <= 0;
        end else begin
            if (fifo_rd_en_a)   a_ptr   <= a_ptr + 1;
            if (fifo_rd_en_sub) sub_ptr <= sub_ptr + 1;
        end
    end

    assign fifo_rd_data_a   = (a_ptr < N)   ? a_mem[a_ptr[AW-1:0]]     : '0;
    assign fifo_rd_data_sub = (sub_ptr < N) ? sub_mem[sub_ptr[AW-1:0]] : '0;

    // ---------------- scoreboard / checking ----------------
    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver: one job ----------------
    task automatic run_job(input bit sign, input bit give_done, input bit stall,
                           input bit hold_start, input int rst_at);
        logic [K-1:0] exp_q[$];
        logic [3:0]   rdy_pat;
        int  p, it, off;
        bit  exp_rd, exp_le;
        int  first_rd, last_rd, rd_cnt, accepted;
        bit  finished;

        rdy_pat  = 4'b1001;   // pattern index 0..3 = 1,0,0,1
        first_rd = -1;
        last_rd  = -1;
        rd_cnt   = 0;
        accepted = 0;
        finished = 1'b0;
        for (int w = 0; w < N; w++) exp_q.push_back(sign ? a_mem[w] : sub_mem[w]);

        @(negedge clk);
        fifo_clr    = 1'b1;
        start_valid = 1'b1;
        cal_done    = 1'b0;
        check("start_ready_idle", 32'(start_ready), 1);
        check("busy_idle", 32'(busy), 0);
        check("err_before_start", 32'(err_timeout), 32'(exp_err));

        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            fifo_clr = 1'b0;
            if (!hold_start) start_valid = 1'b0;
            cal_done  = (give_done && c == LAST_LE + 10) || (hold_start && c == 5);
            cal_sign  = (c == 5) ? !sign : sign;
            res_ready = stall ? rdy_pat[c % 4] : 1'b1;

            if (c == 1) begin
                check("err_cleared_on_start", 32'(err_timeout), 0);
                exp_err = 1'b0;
            end

            if (rd_en) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                rd_cnt++;
            end

            if (c <= LAST_LE + 1) begin
                p      = c - 1;
                it     = p / PERIOD;
                off    = p % PERIOD;
                exp_rd = (p < T_ISSUE) && (off <= N);
                check("rd_en", 32'(rd_en), 32'(exp_rd));
                if (exp_rd) begin
                    check("rd_j_addr", 32'(rd_j_addr), off);
                    check("rd_i_addr", 32'(rd_i_addr), it);
                end
                p      = c - 2;
                it     = (p >= 0) ? p / PERIOD : 0;
                off    = (p >= 0) ? p % PERIOD : 0;
                exp_le = (p >= 0) && (p < T_ISSUE) && (off <= N);
                check("loop_en", 32'(loop_en), 32'(exp_le));
                check("j_cnt", 32'(j_cnt), exp_le ? off : N + 1);
                if (exp_le) check("i_cnt", 32'(i_cnt), it);
                check("start_ready_busy", 32'(start_ready), 0);
                check("busy_run", 32'(busy), 1);
            end

            if (!give_done && rst_at == 0) begin
                if (c == LAST_LE + TO - 1) check("err_early", 32'(err_timeout), 0);
                if (c == LAST_LE + TO) begin
                    check("err_timeout_set", 32'(err_timeout), 1);
                    check("busy_after_timeout", 32'(busy), 0);
                    exp_err = 1'b1;
                end
            end

            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_extra_word", 32'(res_valid), 0);
                end else begin
                    check("res_data", 32'(res_data), 32'(exp_q[0]));
                    check("res_last", 32'(res_last), 32'(exp_q.size() == 1));
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
            end

            if (rst_at != 0 && c == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_loop_en", 32'(loop_en), 0);
                check("rst_j_cnt", 32'(j_cnt), N + 1);
                check("rst_busy", 32'(busy), 0);
                check("rst_start_ready", 32'(start_ready), 1);
                check("rst_rd_en", 32'(rd_en), 0);
                finished = 1'b1;
            end else if (c > LAST_LE + 1 && !busy) begin
                check("start_ready_end", 32'(start_ready), 1);
                check("j_cnt_parked_end", 32'(j_cnt), N + 1);
                finished = 1'b1;
            end
            if (finished) break;
        end

        if (!finished) check("job_cycle_budget", 0, 1);
        if (rst_at == 0) begin
            check("issue_span", last_rd - first_rd + 1, T_ISSUE);
            check("issue_count", rd_cnt, N * (N + 1));
            if (give_done) begin
                check("words_accepted", accepted, N);
                check("exp_q_empty", exp_q.size(), 0);
                check("pops_a", a_ptr, N);
                check("pops_sub", sub_ptr, N);
            end else begin
                check("timeout_pops_a", a_ptr, 0);
                check("timeout_pops_sub", sub_ptr, 0);
                check("timeout_no_output", accepted, 0);
            end
        end
        cal_done  = 1'b0;
        res_ready = 1'b1;
        if (!hold_start) start_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        start_valid = 1'b0;
        cal_done    = 1'b0;
        cal_sign    = 1'b0;
        res_ready   = 1'b1;
        for (int w = 0; w < N; w++) begin
            a_mem[w]   = K'('hA0 + w);
            sub_mem[w] = K'('hB0 + w);
        end

        #12;
        check("reset_start_ready", 32'(start_ready), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_j_cnt", 32'(j_cnt), N + 1);
        check("reset_loop_en", 32'(loop_en), 0);
        check("reset_rd_en", 32'(rd_en), 0);
        check("reset_res_valid", 32'(res_valid), 0);
        check("reset_err", 32'(err_timeout), 0);
        check("reset_pop", 32'(fifo_rd_en_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(1'b1, 1'b1, 1'b0, 1'b0, 0);   // a-path result
        run_job(1'b0, 1'b1, 1'b1, 1'b0, 0);   // sub-path result with stalls
        run_job(1'b1, 1'b0, 1'b0, 1'b0, 0);   // no completion: timeout
        run_job(1'b1, 1'b1, 1'b0, 1'b0, 0);   // start clears the sticky error

        run_job(1'b1, 1'b0, 1'b0, 1'b0, 20);  // reset in the gap after i=2
        @(negedge clk);
        rst_n = 1'b1;
        run_job(1'b1, 1'b1, 1'b0, 1'b0, 0);

        run_job(1'b1, 1'b1, 1'b0, 1'b1, 0);   // start held high, stray cal_done in RUN
        @(negedge clk);
        check("reaccept_busy", 32'(busy), 1);
        check("reaccept_rd_en", 32'(rd_en), 1);
        check("reaccept_rd_j", 32'(rd_j_addr), 0);
        check("reaccept_rd_i", 32'(rd_i_addr), 0);
        start_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
